// File: rtl/led_scanner_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_scanner_gen
// Description : Parametrised LED position scanner. A prescaler produces a
//               step every delay*2**DELAY_SHIFT+1 clocks. Each step moves a
//               position according to one of four run modes: bounce, wrap up,
//               wrap down or fill. The position is decoded onto the LED bank
//               as either a one-hot dot or a bar graph. A rising edge on pause
//               toggles between running and paused.
// Ports       : clk     - clock
//               reset   - synchronous, active-high reset
//               delay   - step period select, sampled at each reload
//               pause   - rising edge toggles run/pause
//               mode    - 00 BOUNCE, 01 WRAP_UP, 10 WRAP_DOWN, 11 FILL
//               led     - LED pattern (combinational decode of pos and mode)
//               pos     - current position, 0..N_LED-1
//               running - 1 = scanning, 0 = paused
//               tick    - one-cycle pulse aligned with each new pos
// Revision    : 1.0 - initial release
// ============================================================================
module led_scanner_gen #(
    parameter  int N_LED       = 10,
    parameter  int DELAY_W     = 4,
    parameter  int DELAY_SHIFT = 20,
    localparam int POS_W       = $clog2(N_LED)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DELAY_W-1:0] delay,
    input  logic               pause,
    input  logic [1:0]         mode,
    output logic [N_LED-1:0]   led,
    output logic [POS_W-1:0]   pos,
    output logic               running,
    output logic               tick
);

    localparam int CNT_W = DELAY_W + DELAY_SHIFT;

    localparam logic [1:0] c_mode_bounce    = 2'b00;
    localparam logic [1:0] c_mode_wrap_up   = 2'b01;
    localparam logic [1:0] c_mode_wrap_down = 2'b10;
    localparam logic [1:0] c_mode_fill      = 2'b11;

    localparam logic c_dir_up   = 1'b0;
    localparam logic c_dir_down = 1'b1;

    localparam logic [POS_W-1:0] c_pos_first = '0;
    localparam logic [POS_W-1:0] c_pos_last  = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] c_pos_penul = POS_W'(N_LED - 2);
    localparam logic [POS_W-1:0] c_pos_one   = POS_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [POS_W-1:0] r_pos;
    logic             r_dir;
    logic             r_running;
    logic             r_pause_q;
    logic             r_tick;

    logic             w_pause_edge;
    logic [POS_W-1:0] w_next_pos;
    logic             w_next_dir;
    logic [CNT_W-1:0] w_reload;

    assign w_pause_edge = pause & ~r_pause_q;
    assign w_reload     = CNT_W'(delay) << DELAY_SHIFT;

    // Next position/direction for a step. dir only matters in BOUNCE but is
    // kept in every mode so a return to BOUNCE continues the old direction.
    always_comb begin
        w_next_pos = r_pos;
        w_next_dir = r_dir;
        case (mode)
            c_mode_bounce: begin
                if (r_dir == c_dir_up) begin
                    if (r_pos == c_pos_last) begin
                        w_next_pos = c_pos_penul;
                        w_next_dir = c_dir_down;
                    end else begin
                        w_next_pos = r_pos + c_pos_one;
                    end
                end else begin
                    if (r_pos == c_pos_first) begin
                        w_next_pos = c_pos_one;
                        w_next_dir = c_dir_up;
                    end else begin
                        w_next_pos = r_pos - c_pos_one;
                    end
                end
            end
            c_mode_wrap_down: begin
                w_next_pos = (r_pos == c_pos_first) ? c_pos_last : r_pos - c_pos_one;
            end
            c_mode_wrap_up, c_mode_fill: begin
                w_next_pos = (r_pos == c_pos_last) ? c_pos_first : r_pos + c_pos_one;
            end
            default: begin
                w_next_pos = r_pos;
            end
        endcase
    end

    // A pause edge takes precedence over a step in the same cycle: the
    // toggle happens and the count is left untouched, so the step is simply
    // deferred until running again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_pos     <= c_pos_first;
            r_dir     <= c_dir_up;
            r_running <= 1'b1;
            r_pause_q <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_pause_q <= pause;
            r_tick    <= 1'b0;
            if (w_pause_edge) begin
                r_running <= ~r_running;
            end else if (r_running) begin
                if (r_count == '0) begin
                    r_count <= w_reload;
                    r_pos   <= w_next_pos;
                    r_dir   <= w_next_dir;
                    r_tick  <= 1'b1;
                end else begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // LED decode: dot for the three scan modes, bar graph for FILL.
    generate
        for (genvar i = 0; i < N_LED; i++) begin : g_led
            localparam logic [POS_W-1:0] c_idx = POS_W'(i);
            assign led[i] = (mode == c_mode_fill) ? (c_idx <= r_pos) : (c_idx == r_pos);
        end
    endgenerate

    assign pos     = r_pos;
    assign running = r_running;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_scanner_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_scanner_gen
// Description : Self-checking bench for led_scanner_gen (N_LED=10,
//               DELAY_SHIFT=2). A behavioural model tracks position, bounce
//               direction, clocks left until the next step and run state,
//               and every clock the DUT outputs are compared with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scanner_gen;

    localparam int N_LED       = 10;
    localparam int DELAY_W     = 4;
    localparam int DELAY_SHIFT = 2;
    localparam int POS_W       = $clog2(N_LED);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [DELAY_W-1:0] delay = 4'd1;
    logic               pause = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [N_LED-1:0]   led;
    logic [POS_W-1:0]   pos;
    logic               running;
    logic               tick;

    led_scanner_gen #(
        .N_LED      (N_LED),
        .DELAY_W    (DELAY_W),
        .DELAY_SHIFT(DELAY_SHIFT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .delay  (delay),
        .pause  (pause),
        .mode   (mode),
        .led    (led),
        .pos    (pos),
        .running(running),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pos  = 0;
    bit m_up   = 1'b1;
    int m_wait = 0;   // clocks remaining before the next step
    bit m_run  = 1'b1;
    bit m_pq   = 1'b0;
    bit m_tick = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_led();
        if (mode == 2'b11) return (1 << (m_pos + 1)) - 1;
        return 1 << m_pos;
    endfunction

    task automatic model_step();
        case (mode)
            2'b00: begin
                if (m_up) begin
                    if (m_pos == N_LED - 1) begin m_pos = N_LED - 2; m_up = 1'b0; end
                    else m_pos = m_pos + 1;
                end else begin
                    if (m_pos == 0) begin m_pos = 1; m_up = 1'b1; end
                    else m_pos = m_pos - 1;
                end
            end
            2'b10:   m_pos = (m_pos + N_LED - 1) % N_LED;
            default: m_pos = (m_pos + 1) % N_LED;
        endcase
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_clock();
        bit edge_seen;
        if (reset) begin
            m_pos = 0; m_up = 1'b1; m_wait = 0; m_run = 1'b1; m_pq = 1'b0; m_tick = 1'b0;
        end else begin
            edge_seen = pause && !m_pq;
            m_pq   = pause;
            m_tick = 1'b0;
            if (edge_seen) begin
                m_run = !m_run;
            end else if (m_run) begin
                if (m_wait == 0) begin
                    m_wait = int'(delay) * (1 << DELAY_SHIFT);
                    model_step();
                    m_tick = 1'b1;
                end else begin
                    m_wait = m_wait - 1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clock();
        #1;
        check("pos", 32'(pos), 32'(m_pos));
        check("led", 32'(led), 32'(model_led()));
        check("running", 32'(running), 32'(m_run));
        check("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Clocks until the DUT shows a tick, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 100);
        if (n >= 100) check("tick_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;

        // 1: reset then BOUNCE with delay=1 (step every 5 clocks)
        run(2);
        check("reset_led", 32'(led), 32'h1);
        check("reset_running", 32'(running), 32'h1);
        reset = 1'b0;
        run(100);

        // 2: WRAP_UP then WRAP_DOWN at delay=0
        mode = 2'b01; delay = 4'd0;
        run(25);
        mode = 2'b10;
        run(25);

        // 3: FILL bar graph
        mode = 2'b11;
        run(22);

        // 4: pause held high for 20 clocks, later a second edge resumes
        mode = 2'b00; delay = 4'd2;
        run(7);
        pause = 1'b1; run(20);
        pause = 1'b0; run(5);
        pause = 1'b1; run(10);
        pause = 1'b0; run(20);

        // 5a: pause edge landing on the step cycle
        for (int i = 0; i < 20 && !(m_wait == 0 && m_run); i++) cyc();
        pause = 1'b1;
        cyc();
        check("edge_no_step_tick", 32'(tick), 32'd0);
        pause = 1'b0; run(3);
        pause = 1'b1; run(3);
        pause = 1'b0; run(2);

        // 5b: pause at pos 7 and reset while paused
        mode = 2'b01; delay = 4'd0;
        for (int i = 0; i < 30 && m_pos != 7; i++) cyc();
        pause = 1'b1;
        run(4);
        check("paused_pos7", 32'(pos), 32'd7);
        check("paused_run", 32'(running), 32'd0);
        reset = 1'b1; pause = 1'b0;
        cyc();
        reset = 1'b0;
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_led", 32'(led), 32'h1);
        check("rst_running", 32'(running), 32'd1);

        // 6: delay change mid-count affects only the following period
        delay = 4'd1;
        wait_tick(n);
        wait_tick(n);
        check("period_d1", 32'(n), 32'd5);
        run(2);
        delay = 4'd3;
        wait_tick(n);
        check("period_rest", 32'(n), 32'd3);
        wait_tick(n);
        check("period_d3", 32'(n), 32'd13);

        // Randomised mix of modes, delays, pause edges and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) delay = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            reset = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
